fifo_drain: RTL and testbench



---
 rtl/fifo_drain_if.sv | 23 ++
 rtl/fifo_drain.sv | 61 ++++++
 tb/tb_fifo_drain.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
// Handshake bundle for fifo_drain: FIFO read side, downstream valid/ready stream
// and skid-buffer occupancy.
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  down_valid;
  logic                  down_ready;
  logic [DATA_WIDTH-1:0] down_data;
  logic [1:0]            level;

  modport master (
    input  fifo_empty, fifo_data, down_ready,
    output fifo_pop, down_valid, down_data, level
  );

  modport slave (
    output fifo_empty, fifo_data, down_ready,
    input  fifo_pop, down_valid, down_data, level
  );
endinterface

// File: rtl/fifo_drain.sv
// Read-side adapter: converts a 1-cycle-latency FIFO pop interface into a
// valid/ready stream via a 3-entry skid buffer; pops are issued from registers only.
module fifo_drain #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fifo_drain_if.master   bus
);
  logic [DATA_WIDTH-1:0] r_buf [3];
  logic [1:0]            r_wr;
  logic [1:0]            r_rd;
  logic [1:0]            r_level;
  logic                  r_inflight;

  logic [2:0]            w_occ;
  logic                  w_pop;
  logic                  w_xfer;
  logic [1:0]            w_level_next;

  function automatic logic [1:0] f_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Count the in-flight word so a pop can never overrun the buffer on capture.
  assign w_occ        = {1'b0, r_level} + {2'b00, r_inflight};
  assign w_pop        = ~bus.fifo_empty & (w_occ < 3'd3);
  assign w_xfer       = (r_level != 2'd0) & bus.down_ready;
  assign w_level_next = r_level + {1'b0, r_inflight} - {1'b0, w_xfer};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr       <= 2'd0;
      r_rd       <= 2'd0;
      r_level    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      if (r_inflight) r_wr <= f_inc(r_wr);
      if (w_xfer)     r_rd <= f_inc(r_rd);
      r_level    <= w_level_next;
    end
  end

  // Storage carries no reset; contents are meaningless while level is 0.
  always_ff @(posedge i_clk) begin
    if (r_inflight) r_buf[r_wr] <= bus.fifo_data;
  end

  assign bus.fifo_pop   = w_pop;
  assign bus.down_valid = (r_level != 2'd0);
  assign bus.down_data  = r_buf[r_rd];
  assign bus.level      = r_level;

  a_occ_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    w_occ <= 3'd3);
  a_pop_not_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.fifo_pop |-> ~bus.fifo_empty);
  a_stall_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (bus.down_valid & ~bus.down_ready) |=> (bus.down_valid & $stable(bus.down_data)));
endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based FIFO model upstream, scoreboard monitor
// downstream, directed scenarios followed by randomized push/ready traffic.
module tb_fifo_drain;
  logic clk;
  logic rst;

  fifo_drain_if #(.DATA_WIDTH(16)) bus ();

  fifo_drain #(.DATA_WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] fifo_q [$];
  logic [15:0] exp_q  [$];
  int          pop_cnt;
  int          xfer_cnt;
  int          last_pop;
  int          n_checks;
  int          n_fail;
  bit          prev_stall;
  logic [15:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO: registered empty flag, read data one cycle after the pop.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      pop_cnt  = 0;
      xfer_cnt = 0;
      last_pop = 0;
      bus.fifo_empty <= 1'b1;
    end else begin
      last_pop = (bus.fifo_pop && !bus.fifo_empty) ? 1 : 0;
      if (bus.fifo_pop && !bus.fifo_empty) begin
        pop_cnt++;
        if (fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
      end
      if (bus.down_valid && bus.down_ready) xfer_cnt++;
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: words held by the adapter = pops - transfers; the word popped on the
  // last edge is still in flight, the rest must show up in level.
  always @(negedge clk) begin
    int held;
    if (!rst) begin
      held = pop_cnt - xfer_cnt;
      check("level_model", 32'(bus.level), 32'(held - last_pop));
      check("occupancy_le3", 32'(held <= 3), 32'd1);
      check("valid_vs_level", 32'(bus.down_valid), 32'((held - last_pop) != 0));
      if (bus.fifo_pop) check("pop_not_empty", 32'(bus.fifo_empty), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(bus.down_valid), 32'd1);
        check("stall_data", 32'(bus.down_data), 32'(prev_data));
      end
      if (bus.down_valid && bus.down_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", bus.down_data, $time);
        end else begin
          check("sb_data", 32'(bus.down_data), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = bus.down_valid && !bus.down_ready;
      prev_data  = bus.down_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_valid(input string name, input int lim);
    int n;
    n = 0;
    while (!bus.down_valid && n < lim) begin
      tick();
      n++;
    end
    check(name, 32'(bus.down_valid), 32'd1);
  endtask

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    bus.down_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.down_valid) && n < lim) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    int sent;
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.down_ready = 1'b0;
    bus.fifo_data  = 16'h0;
    tick();
    tick();
    check("rst_valid", 32'(bus.down_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_pop", 32'(bus.fifo_pop), 32'd0);
    rst = 1'b0;
    tick();

    // Single word latency: pop in N, valid in N+2.
    push(16'h0001);
    n = 0;
    while (!bus.fifo_pop && n < 10) begin tick(); n++; end
    check("lat_pop_seen", 32'(bus.fifo_pop), 32'd1);
    tick();
    check("lat_n1_valid", 32'(bus.down_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(bus.down_valid), 32'd1);
    check("lat_n2_data", 32'(bus.down_data), 32'h0001);
    check("lat_n2_level", 32'(bus.level), 32'd1);
    drain("drain_single", 20);

    // Streaming: 8 preloaded words, no bubbles once the first is out.
    for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
    bus.down_ready = 1'b1;
    wait_valid("stream_first", 10);
    for (int i = 0; i < 8; i++) begin
      check("stream_nobubble", 32'(bus.down_valid), 32'd1);
      tick();
    end
    tick();
    check("stream_pop_idle", 32'(bus.fifo_pop), 32'd0);
    check("stream_empty", 32'(bus.fifo_empty), 32'd1);
    drain("drain_stream", 20);

    // Backpressure: only three words may be pulled.
    bus.down_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i));
    for (int i = 0; i < 12; i++) tick();
    check("bp_pops", 32'(pop_cnt - p0), 32'd3);
    check("bp_level", 32'(bus.level), 32'd3);
    check("bp_pop_off", 32'(bus.fifo_pop), 32'd0);
    check("bp_head", 32'(bus.down_data), 32'h0020);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      bus.down_ready = (n % 2 == 0);
      tick();
      n++;
    end
    check("toggle_drained", 32'(exp_q.size()), 32'd0);
    drain("drain_toggle", 20);

    // Reset while two words are stored and one is in flight.
    bus.down_ready = 1'b0;
    push(16'h0030);
    push(16'h0031);
    push(16'h0032);
    n = 0;
    while (!(bus.level == 2'd2 && last_pop == 1) && n < 20) begin tick(); n++; end
    check("pre_rst_level", 32'(bus.level), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_valid", 32'(bus.down_valid), 32'd0);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_pop", 32'(bus.fifo_pop), 32'd0);
    rst = 1'b0;
    tick();
    push(16'h00AA);
    wait_valid("post_rst_valid", 10);
    check("post_rst_data", 32'(bus.down_data), 32'h00AA);
    drain("drain_post_rst", 20);

    // Random traffic.
    sent = 0;
    while (sent < 1000) begin
      if ($urandom_range(0, 3) != 0) begin
        push(16'($urandom));
        sent++;
      end
      bus.down_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain("drain_random", 3000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
